// File: rtl/mms_tx_sched.sv
// MAC Merge transmit scheduler: arbitrates express, preemptable and verify/respond traffic
// with frame preemption and resume. Define MMS_TX_STATS_EN to build the preemption counter.
module mms_tx_sched #(
    parameter int IPG_OCT = 12,
    parameter int VR_LEN  = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p_enable,
    input  logic        verified,
    input  logic        disable_verify,
    input  logic [1:0]  add_frag_size,
    input  logic        e_valid,
    input  logic        e_last,
    input  logic        p_valid,
    input  logic        p_last,
    input  logic        send_v,
    input  logic        send_r,
    output logic        e_ready,
    output logic        p_ready,
    output logic [1:0]  tx_src,
    output logic [2:0]  tx_smd,
    output logic        tx_start,
    output logic        tx_term,
    output logic [1:0]  frag_cnt,
    output logic        v_done,
    output logic        r_done,
    output logic [15:0] preempt_count
);

    localparam int WW = (IPG_OCT > 1) ? $clog2(IPG_OCT) : 1;

    localparam logic [1:0] SRC_IDLE = 2'd0;
    localparam logic [1:0] SRC_E    = 2'd1;
    localparam logic [1:0] SRC_P    = 2'd2;
    localparam logic [1:0] SRC_VR   = 2'd3;

    localparam logic [2:0] SMD_E = 3'd0;
    localparam logic [2:0] SMD_S = 3'd1;
    localparam logic [2:0] SMD_C = 3'd2;
    localparam logic [2:0] SMD_V = 3'd3;
    localparam logic [2:0] SMD_R = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_IPG, S_EXPRESS, S_PMAC, S_HOLD, S_VR} state_t;

    state_t        state;
    state_t        arb_state;
    logic          held;
    logic          start_pend;
    logic [10:0]   oct_cnt;
    logic [WW-1:0] wcnt;
    logic [7:0]    min_frag;
    logic [7:0]    min_frag_now;
    logic          preempt_ok;
    logic          preempt;
    logic          vr_octet;
    logic          wait_last;
    logic          launch;
    logic          arb_go;
    logic [1:0]    arb_src;
    logic [2:0]    arb_smd;

    assign preempt_ok   = p_enable && (verified || disable_verify);
    assign min_frag_now = {add_frag_size, 6'd0} + 8'd60;
    assign wait_last    = (wcnt == WW'(IPG_OCT - 1));

    always_comb begin
        arb_go    = 1'b1;
        arb_state = S_IDLE;
        arb_src   = SRC_IDLE;
        arb_smd   = SMD_E;
        if (e_valid) begin
            arb_state = S_EXPRESS;
            arb_src   = SRC_E;
            arb_smd   = SMD_E;
        end else if (held) begin
            arb_state = S_PMAC;
            arb_src   = SRC_P;
            arb_smd   = SMD_C;
        end else if (send_r) begin
            arb_state = S_VR;
            arb_src   = SRC_VR;
            arb_smd   = SMD_R;
        end else if (send_v) begin
            arb_state = S_VR;
            arb_src   = SRC_VR;
            arb_smd   = SMD_V;
        end else if (p_valid) begin
            arb_state = S_PMAC;
            arb_src   = SRC_P;
            arb_smd   = SMD_S;
        end else begin
            arb_go    = 1'b0;
        end
    end

    // A fragment may only be cut once it reaches min_frag and never on its final octet.
    assign preempt  = (state == S_PMAC) && e_valid && preempt_ok && !start_pend &&
                      (oct_cnt >= {3'd0, min_frag}) && !(p_valid && p_last);
    assign e_ready  = (state == S_EXPRESS) && e_valid;
    assign p_ready  = (state == S_PMAC) && p_valid && !preempt;
    assign vr_octet = (state == S_VR);
    assign tx_term  = preempt;
    assign tx_start = start_pend && (e_ready || p_ready || vr_octet);
    // Arbitration also runs in the last IPG cycle so back-to-back traffic sees exactly IPG_OCT idles.
    assign launch   = arb_go && ((state == S_IDLE) || ((state == S_IPG) && wait_last));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            held       <= 1'b0;
            start_pend <= 1'b0;
            oct_cnt    <= '0;
            wcnt       <= '0;
            min_frag   <= 8'd60;
            tx_src     <= SRC_IDLE;
            tx_smd     <= SMD_E;
            frag_cnt   <= 2'd0;
            v_done     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            v_done <= 1'b0;
            r_done <= 1'b0;
            if (e_ready || p_ready || vr_octet) begin
                start_pend <= 1'b0;
                if (oct_cnt != 11'h7FF) oct_cnt <= oct_cnt + 11'd1;
            end
            case (state)
                S_IDLE: ;
                S_IPG: begin
                    if (wait_last) state <= S_IDLE;
                    else wcnt <= wcnt + WW'(1);
                end
                S_EXPRESS: begin
                    if (e_ready && e_last) begin
                        state  <= S_IPG;
                        wcnt   <= '0;
                        tx_src <= SRC_IDLE;
                    end
                end
                S_PMAC: begin
                    if (preempt) begin
                        held   <= 1'b1;
                        state  <= S_HOLD;
                        wcnt   <= '0;
                        tx_src <= SRC_IDLE;
                    end else if (p_ready && p_last) begin
                        held   <= 1'b0;
                        state  <= S_IPG;
                        wcnt   <= '0;
                        tx_src <= SRC_IDLE;
                    end
                end
                S_HOLD: begin
                    if (wait_last) begin
                        state      <= S_EXPRESS;
                        tx_src     <= SRC_E;
                        tx_smd     <= SMD_E;
                        start_pend <= 1'b1;
                        oct_cnt    <= '0;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                S_VR: begin
                    if (oct_cnt == 11'(VR_LEN - 1)) begin
                        v_done <= (tx_smd == SMD_V);
                        r_done <= (tx_smd == SMD_R);
                        state  <= S_IPG;
                        wcnt   <= '0;
                        tx_src <= SRC_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (launch) begin
                state      <= arb_state;
                tx_src     <= arb_src;
                tx_smd     <= arb_smd;
                start_pend <= 1'b1;
                oct_cnt    <= '0;
                if (arb_smd == SMD_S) begin
                    frag_cnt <= 2'd0;
                    min_frag <= min_frag_now;
                end else if (arb_smd == SMD_C) begin
                    frag_cnt <= frag_cnt + 2'd1;
                end
            end
        end
    end

`ifdef MMS_TX_STATS_EN
    logic [15:0] pcnt;

    always_ff @(posedge clk) begin
        if (!reset_n) pcnt <= '0;
        else if (preempt && (pcnt != 16'hFFFF)) pcnt <= pcnt + 16'd1;
    end

    assign preempt_count = pcnt;
`else
    assign preempt_count = 16'd0;
`endif

endmodule

// File: doc/mms_tx_sched.md
MMS_TX_SCHED -- requirements
Module: mms_tx_sched

Interface
REQ-001 Parameter IPG_OCT, default 12: idle octet-cycles inserted after every frame, fragment or mPacket.
REQ-002 Parameter VR_LEN, default 60: octet-cycles in one verify or respond mPacket body.
REQ-003 Port clk  input  1: single clock; one octet per cycle.
REQ-004 Port reset_n  input  1: reset, synchronous and active-low.
REQ-005 Port p_enable, verified, disable_verify  input  1 each: preemption enable and verify status from the MAC Merge verify function.
REQ-006 Port add_frag_size  input  2: minimum fragment selector.
REQ-007 Port e_valid, e_last  input  1 each: express MAC octet available; last octet of the frame.
REQ-008 Port p_valid, p_last  input  1 each: preemptable MAC octet available; last octet of the frame.
REQ-009 Port send_v, send_r  input  1 each: level requests to transmit a verify or respond mPacket.
REQ-010 Port e_ready, p_ready  output  1 each: the octet is consumed this cycle (valid and ready both high).
REQ-011 Port tx_src  output  2: 0 = idle, 1 = express, 2 = pMAC, 3 = verify/respond.
REQ-012 Port tx_smd  output  3: SMD type, valid only while tx_start is high: 0 = SMD-E, 1 = SMD-S, 2 = SMD-C, 3 = SMD-V, 4 = SMD-R.
REQ-013 Port tx_start  output  1: one-cycle pulse on the first octet of a frame, fragment or mPacket.
REQ-014 Port tx_term  output  1: one-cycle pulse marking the fragment end on preemption (mCRC point).
REQ-015 Port frag_cnt  output  2: fragment count for the current pMAC frame, mod 4.
REQ-016 Port v_done, r_done  output  1 each: one-cycle pulse when an mPacket completes.
REQ-017 Port preempt_count  output  16: preemption statistic (see REQ-036).

Function
REQ-018 States: IDLE, IPG, EXPRESS, PMAC, HOLD, VR.
REQ-019 preempt_ok = p_enable && (verified || disable_verify), evaluated combinationally every cycle.
REQ-020 min_frag = 64*(add_frag_size+1)-4, giving 60/124/188/252 octets, sampled at pMAC frame start.
REQ-021 Octet counter: 11 bits, saturates at 2047, cleared at every tx_start.
REQ-022 IDLE arbitration, fixed priority:
  - e_valid -> EXPRESS, SMD-E.
  - held pMAC frame -> PMAC, SMD-C, frag_cnt+1.
  - send_r -> VR, SMD-R.
  - send_v -> VR, SMD-V.
  - p_valid -> PMAC, SMD-S, frag_cnt=0.
REQ-023 EXPRESS: e_ready = e_valid. A consumed e_last -> IPG. e_valid low mid-frame stalls the state with tx_src held at 1.
REQ-024 PMAC: p_ready = p_valid. A consumed p_last -> IPG and clears the held flag.
REQ-025 Preemption occurs when all hold in PMAC: e_valid && preempt_ok && counter >= min_frag && the current octet is not p_last. Response in that same cycle:
  - p_ready = 0.
  - tx_term pulses.
  - Sets the held flag, increments preempt_count, -> HOLD.
REQ-026 HOLD lasts IPG_OCT cycles, then -> EXPRESS with SMD-E, bypassing IDLE.
REQ-027 After the express frame and its IPG, the scheduler returns to IDLE; a further e_valid still wins before the resume (REQ-022).
REQ-028 If preempt_ok is low, express waits until the pMAC frame ends.
REQ-029 If preempt_ok falls while a pMAC frame is held, the resume still occurs.
REQ-030 VR: VR_LEN cycles, tx_src = 3, then pulse v_done or r_done -> IPG.
REQ-031 VR is never preempted.
REQ-032 If send_v and send_r are both high, respond goes first and verify follows after IPG.
REQ-033 IPG: IPG_OCT cycles with tx_src = 0, then -> IDLE.
REQ-034 frag_cnt wraps from 3 to 0.

Reset
REQ-035 reset_n low at any clock edge, including mid-frame or mid-HOLD, sets the following:
  - state = IDLE.
  - Held flag, counters, frag_cnt and all pulse outputs = 0.
  - tx_src = 0, e_ready = p_ready = 0.
  - preempt_count = 0.

Configuration
REQ-036 Macro MMS_TX_STATS_EN:
  - Defined: preempt_count increments once per preemption and saturates at 65535.
  - Undefined: the counter logic is omitted and preempt_count is constant 0.

Verification
REQ-037 p_valid, 200-octet frame, no e_valid -> tx_start with SMD-S; 200 p_ready cycles; 12 idle cycles; preempt_count = 0.
REQ-038 verified = 1, p_enable = 1, add_frag_size = 0, 200-octet pMAC frame, e_valid raised at pMAC octet 10 -> tx_term at octet 60; 12-cycle HOLD; express frame with SMD-E; IPG; resume with SMD-C, frag_cnt = 1, remaining 140 octets.
REQ-039 Same stimulus as REQ-038 with verified = 0 and disable_verify = 0 -> no tx_term; express starts only after the pMAC frame's IPG.
REQ-040 send_v and send_r raised together in IDLE -> 60-cycle SMD-R mPacket, r_done, 12-cycle IPG, then 60-cycle SMD-V mPacket, v_done.
REQ-041 Four preemptions of one pMAC frame with add_frag_size = 0 -> frag_cnt sequence 1, 2, 3, 0; preempt_count = 4, or 0 with the macro undefined.
REQ-042 reset_n low during HOLD -> next cycle IDLE with all outputs 0; a later p_valid starts with SMD-S and frag_cnt = 0.
